instr_dispatcher: RTL and testbench



---
 rtl/instr_dispatcher_pkg.sv | 29 ++
 rtl/instr_dispatcher_if.sv | 41 ++++
 rtl/instr_decoder.sv | 17 +
 rtl/instr_dispatcher.sv | 96 +++++++++
 tb/tb_instr_dispatcher.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_dispatcher_pkg.sv
// tpu_pkg: instruction format, opcode-class constants and dispatcher state/class types
package tpu_pkg;
  localparam int OPCODE_WIDTH = 8;
  localparam int OPERAND_WIDTH = 24;
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [OPERAND_WIDTH-1:0] operand;
  } instr_type;
  localparam instr_type INIT_INSTR = '0;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_HALT = 8'h01;
  localparam logic [7:0] OP_SYNC = 8'hFF;
  localparam logic [7:0] OP_WEIGHT_MASK = 8'hF8;
  localparam logic [7:0] OP_WEIGHT_VAL = 8'h08;
  localparam logic [7:0] OP_MATRIX_MASK = 8'hE0;
  localparam logic [7:0] OP_MATRIX_VAL = 8'h20;
  localparam logic [7:0] OP_ACT_MASK = 8'h80;
  localparam logic [7:0] OP_ACT_VAL = 8'h80;
  typedef enum logic [1:0] {S_RUN, S_SYNC_WAIT, S_HALT} dispatch_state_type;
  typedef struct packed {
    logic nop;
    logic halt;
    logic sync;
    logic weight;
    logic matrix;
    logic activation;
    logic illegal;
  } instr_class_type;
endpackage

// File: rtl/instr_dispatcher_if.sv
// instr_dispatcher_if: look-ahead buffer and control-unit signals of the dispatcher (TPU_DISPATCH_PERF_EN adds perf counters)
interface instr_dispatcher_if;
  import tpu_pkg::*;
  instr_type   instr_in;
  logic        instr_read;
  logic        instr_busy;
  logic        weight_en;
  logic        matrix_en;
  logic        activation_en;
  instr_type   weight_instr;
  instr_type   matrix_instr;
  instr_type   activation_instr;
  logic        weight_busy;
  logic        matrix_busy;
  logic        activation_busy;
  logic        synchronize;
  logic        halted;
  logic        illegal_instr;
`ifdef TPU_DISPATCH_PERF_EN
  logic [31:0] perf_issue_count;
  logic [31:0] perf_stall_count;
`endif
  modport slave (
    input  instr_in, instr_read, weight_busy, matrix_busy, activation_busy,
    output instr_busy, weight_en, matrix_en, activation_en,
           weight_instr, matrix_instr, activation_instr,
           synchronize, halted, illegal_instr
`ifdef TPU_DISPATCH_PERF_EN
  , output perf_issue_count, perf_stall_count
`endif
  );
  modport master (
    output instr_in, instr_read, weight_busy, matrix_busy, activation_busy,
    input  instr_busy, weight_en, matrix_en, activation_en,
           weight_instr, matrix_instr, activation_instr,
           synchronize, halted, illegal_instr
`ifdef TPU_DISPATCH_PERF_EN
  , input perf_issue_count, perf_stall_count
`endif
  );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: opcode to one-hot instruction class
module instr_decoder
  import tpu_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output instr_class_type         o_cls
);
  logic w_nop, w_halt, w_sync, w_weight, w_matrix, w_act;
  assign w_nop    = i_opcode == OP_NOP;
  assign w_halt   = i_opcode == OP_HALT;
  assign w_sync   = i_opcode == OP_SYNC;
  assign w_weight = (i_opcode & OP_WEIGHT_MASK) == OP_WEIGHT_VAL;
  assign w_matrix = (i_opcode & OP_MATRIX_MASK) == OP_MATRIX_VAL;
  assign w_act    = ((i_opcode & OP_ACT_MASK) == OP_ACT_VAL) && !w_sync;
  assign o_cls = '{nop: w_nop, halt: w_halt, sync: w_sync, weight: w_weight, matrix: w_matrix,
                   activation: w_act, illegal: !(w_nop | w_halt | w_sync | w_weight | w_matrix | w_act)};
endmodule

// File: rtl/instr_dispatcher.sv
// instr_dispatcher: issues pending instructions to weight/matrix/activation units; TPU_DISPATCH_PERF_EN adds perf counters
module instr_dispatcher
  import tpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  instr_dispatcher_if.slave  bus
);
  dispatch_state_type r_state, w_state_nxt;
  logic               r_pend_valid;
  instr_type          r_pend_instr;
  logic               r_weight_en, r_matrix_en, r_act_en, r_sync, r_illegal;
  instr_type          r_weight_instr, r_matrix_instr, r_act_instr;
  instr_class_type    w_cls;
  logic               w_idle, w_fire, w_busy, w_load, w_all_idle;

  instr_decoder u_dec (.i_opcode(r_pend_instr.opcode), .o_cls(w_cls));

  // A unit counts as idle only once its strobe has dropped, covering its busy-assert latency
  assign w_idle = w_cls.weight     ? !bus.weight_busy && !r_weight_en :
                  w_cls.matrix     ? !bus.matrix_busy && !r_matrix_en :
                  w_cls.activation ? !bus.activation_busy && !r_act_en :
                  (w_cls.nop | w_cls.illegal | w_cls.halt | w_cls.sync);
  assign w_fire     = r_pend_valid && r_state == S_RUN && w_idle;
  assign w_busy     = r_state != S_RUN || (r_pend_valid && !w_fire);
  assign w_load     = bus.instr_read && !w_busy && enable;
  assign w_all_idle = !(bus.weight_busy | bus.matrix_busy | bus.activation_busy |
                        r_weight_en | r_matrix_en | r_act_en);

  // Next state: sync and halt serialise the stream once they fire
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RUN && w_fire)
      w_state_nxt = w_cls.sync ? S_SYNC_WAIT : w_cls.halt ? S_HALT : S_RUN;
    else if (r_state == S_SYNC_WAIT && w_all_idle)
      w_state_nxt = S_RUN;
  end

  // State register, frozen while enable is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_RUN;
    else if (enable) r_state <= w_state_nxt;

  // Pending register, issue strobes, sync pulse and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend_valid   <= 1'b0;
      r_pend_instr   <= INIT_INSTR;
      r_weight_en    <= 1'b0;
      r_matrix_en    <= 1'b0;
      r_act_en       <= 1'b0;
      r_weight_instr <= INIT_INSTR;
      r_matrix_instr <= INIT_INSTR;
      r_act_instr    <= INIT_INSTR;
      r_sync         <= 1'b0;
      r_illegal      <= 1'b0;
    end else if (enable) begin
      r_pend_valid <= w_load || (r_pend_valid && !w_fire);
      if (w_load) r_pend_instr <= bus.instr_in;
      r_weight_en <= w_fire && w_cls.weight;
      r_matrix_en <= w_fire && w_cls.matrix;
      r_act_en    <= w_fire && w_cls.activation;
      if (w_fire && w_cls.weight) r_weight_instr <= r_pend_instr;
      if (w_fire && w_cls.matrix) r_matrix_instr <= r_pend_instr;
      if (w_fire && w_cls.activation) r_act_instr <= r_pend_instr;
      r_sync <= r_state == S_SYNC_WAIT && w_all_idle;
      if (w_fire && w_cls.illegal) r_illegal <= 1'b1;
    end

  assign bus.instr_busy       = w_busy;
  assign bus.weight_en        = r_weight_en;
  assign bus.matrix_en        = r_matrix_en;
  assign bus.activation_en    = r_act_en;
  assign bus.weight_instr     = r_weight_instr;
  assign bus.matrix_instr     = r_matrix_instr;
  assign bus.activation_instr = r_act_instr;
  assign bus.synchronize      = r_sync;
  assign bus.halted           = r_state == S_HALT;
  assign bus.illegal_instr    = r_illegal;

`ifdef TPU_DISPATCH_PERF_EN
  logic [31:0] r_issue_cnt, r_stall_cnt;
  // Count issue strobes and busy cycles, both wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (enable) begin
      if (r_weight_en | r_matrix_en | r_act_en) r_issue_cnt <= r_issue_cnt + 32'd1;
      if (w_busy) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  assign bus.perf_issue_count = r_issue_cnt;
  assign bus.perf_stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_instr_dispatcher.sv
// tb_instr_dispatcher: directed self-checking bench for instr_dispatcher
module tb_instr_dispatcher;
  import tpu_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  int   n_vec = 0;
  int   n_fail = 0;
  instr_dispatcher_if bus();
  instr_dispatcher dut (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] op);
    return {op, 16'h5A00, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".wen"}, bus.weight_en, 0);
    chk({tag, ".men"}, bus.matrix_en, 0);
    chk({tag, ".aen"}, bus.activation_en, 0);
    chk({tag, ".winstr"}, bus.weight_instr, INIT_INSTR);
    chk({tag, ".minstr"}, bus.matrix_instr, INIT_INSTR);
    chk({tag, ".ainstr"}, bus.activation_instr, INIT_INSTR);
    chk({tag, ".sync"}, bus.synchronize, 0);
    chk({tag, ".halted"}, bus.halted, 0);
    chk({tag, ".illegal"}, bus.illegal_instr, 0);
    chk({tag, ".busy"}, bus.instr_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    bus.instr_in = '0;
    bus.instr_read = 1'b0;
    bus.weight_busy = 1'b0;
    bus.matrix_busy = 1'b0;
    bus.activation_busy = 1'b0;
    #3;
    chk_rst("reset");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_reset.busy", bus.instr_busy, 0);
    // weight then matrix back-to-back to idle units
    bus.instr_in = mk(8'h08);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_in = mk(8'h20);
    chk("b2b.busy0", bus.instr_busy, 0);
    chk("b2b.wen0", bus.weight_en, 0);
    tick();
    bus.instr_read = 1'b0;
    chk("b2b.wen1", bus.weight_en, 1);
    chk("b2b.winstr", bus.weight_instr, mk(8'h08));
    chk("b2b.busy1", bus.instr_busy, 0);
    tick();
    chk("b2b.men", bus.matrix_en, 1);
    chk("b2b.minstr", bus.matrix_instr, mk(8'h20));
    chk("b2b.wen_off", bus.weight_en, 0);
    chk("b2b.busy2", bus.instr_busy, 0);
    // two matrix instructions, unit busy for 5 cycles after the first
    bus.instr_in = mk(8'h21);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_in = mk(8'h22);
    chk("mm.busy0", bus.instr_busy, 0);
    tick();
    bus.instr_read = 1'b0;
    bus.matrix_busy = 1'b1;
    #1;
    chk("mm.men1", bus.matrix_en, 1);
    chk("mm.minstr1", bus.matrix_instr, mk(8'h21));
    chk("mm.busy_a", bus.instr_busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mm.busy_hold", bus.instr_busy, 1);
      chk("mm.men_hold", bus.matrix_en, 0);
    end
    tick();
    bus.matrix_busy = 1'b0;
    #1;
    chk("mm.busy_free", bus.instr_busy, 0);
    chk("mm.men_free", bus.matrix_en, 0);
    tick();
    chk("mm.men2", bus.matrix_en, 1);
    chk("mm.minstr2", bus.matrix_instr, mk(8'h22));
    // sync while activation busy 4 cycles, weight following
    bus.activation_busy = 1'b1;
    bus.instr_in = mk(8'hFF);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_in = mk(8'h09);
    #1;
    chk("sync.busy_fire", bus.instr_busy, 0);
    tick();
    bus.instr_read = 1'b0;
    chk("sync.busy_w0", bus.instr_busy, 1);
    chk("sync.pulse_w0", bus.synchronize, 0);
    tick();
    chk("sync.busy_w1", bus.instr_busy, 1);
    chk("sync.pulse_w1", bus.synchronize, 0);
    tick();
    bus.activation_busy = 1'b0;
    #1;
    chk("sync.busy_w2", bus.instr_busy, 1);
    chk("sync.pulse_w2", bus.synchronize, 0);
    chk("sync.wen_held", bus.weight_en, 0);
    tick();
    chk("sync.pulse", bus.synchronize, 1);
    chk("sync.busy_run", bus.instr_busy, 0);
    chk("sync.wen_pre", bus.weight_en, 0);
    tick();
    chk("sync.pulse_end", bus.synchronize, 0);
    chk("sync.wen", bus.weight_en, 1);
    chk("sync.winstr", bus.weight_instr, mk(8'h09));
    // illegal opcode
    bus.instr_in = mk(8'h40);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_read = 1'b0;
    chk("ill.pre", bus.illegal_instr, 0);
    tick();
    chk("ill.set", bus.illegal_instr, 1);
    chk("ill.wen", bus.weight_en, 0);
    chk("ill.men", bus.matrix_en, 0);
    chk("ill.aen", bus.activation_en, 0);
    tick();
    chk("ill.sticky", bus.illegal_instr, 1);
    // activation strobe held across enable low
    bus.instr_in = mk(8'h80);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_read = 1'b0;
    tick();
    enable = 1'b0;
    chk("en.aen", bus.activation_en, 1);
    chk("en.ainstr", bus.activation_instr, mk(8'h80));
    tick();
    chk("en.aen_held", bus.activation_en, 1);
    enable = 1'b1;
    tick();
    chk("en.aen_off", bus.activation_en, 0);
    // halt
    bus.instr_in = mk(8'h01);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_in = mk(8'h08);
    tick();
    chk("halt.halted", bus.halted, 1);
    chk("halt.busy", bus.instr_busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt.hold", bus.halted, 1);
      chk("halt.busy_hold", bus.instr_busy, 1);
      chk("halt.wen", bus.weight_en, 0);
    end
    bus.instr_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt.async_rst", bus.halted, 0);
    chk("halt.rst_illegal", bus.illegal_instr, 0);
    tick();
    rst_n = 1'b1;
    // reset during an issue strobe
    bus.instr_in = mk(8'h0A);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_read = 1'b0;
    tick();
    chk("rmid.wen", bus.weight_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("rmid");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rmid.lost", bus.weight_en, 0);
`ifdef TPU_DISPATCH_PERF_EN
    chk("perf.issue0", bus.perf_issue_count, 0);
    chk("perf.stall0", bus.perf_stall_count, 0);
    bus.instr_in = mk(8'h08);
    bus.instr_read = 1'b1;
    tick();
    bus.instr_in = mk(8'h20);
    tick();
    bus.instr_in = mk(8'h80);
    tick();
    bus.weight_busy = 1'b1;
    bus.instr_in = mk(8'h0B);
    tick();
    bus.instr_read = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.weight_busy = 1'b0;
    #1;
    chk("perf.issue", bus.perf_issue_count, 3);
    chk("perf.stall", bus.perf_stall_count, 5);
    tick();
    tick();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
